mnist_argmax: RTL and testbench

Classifier head placed directly downstream of the MNIST network top. It consumes the final layer's logit stream, which is CHANNEL signed values per beat. It sums each channel over the SIZE*SIZE spatial beats of one image, then scans the sums sequentially for the maximum. It reports the winning class index and its score with a one-cycle valid pulse.

---
 rtl/mnist_argmax_if.sv | 29 ++
 rtl/mnist_argmax.sv | 124 ++++++++++++
 tb/tb_mnist_argmax.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mnist_argmax_if.sv
// Logit stream in, classification result and status flags out.
interface mnist_argmax_if #(
  parameter int unsigned N       = 8,
  parameter int unsigned CHANNEL = 10,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned CLASS_W = 4
);
  logic                   input_vld;
  logic [CHANNEL*N-1:0]   input_din;
  logic                   input_end;
  logic [CLASS_W-1:0]     class_dout;
  logic [ACC_W-1:0]       score_dout;
  logic                   class_vld;
  logic                   busy;
  logic                   frame_err;
  logic                   drop_err;

  // Upstream producer / result consumer side.
  modport master (
    output input_vld, input_din, input_end,
    input  class_dout, score_dout, class_vld, busy, frame_err, drop_err
  );

  // Classifier side.
  modport slave (
    input  input_vld, input_din, input_end,
    output class_dout, score_dout, class_vld, busy, frame_err, drop_err
  );
endinterface

// File: rtl/mnist_argmax.sv
// Classifier head: sums each logit channel over one image, then scans the
// sums for the strict signed maximum (lowest index wins ties).
module mnist_argmax #(
  parameter int unsigned N       = 8,
  parameter int unsigned CHANNEL = 10,
  parameter int unsigned SIZE    = 1,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned CLASS_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mnist_argmax_if.slave    io
);
  localparam int unsigned BEATS = SIZE * SIZE;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(CHANNEL - 1);

  typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_t;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc [CHANNEL];
  logic signed [ACC_W-1:0]   ext [CHANNEL];
  logic [CNT_W-1:0]          cnt;
  logic [CLASS_W-1:0]        idx;
  logic signed [ACC_W-1:0]   best;
  logic [CLASS_W-1:0]        best_idx;
  logic [CLASS_W-1:0]        class_q;
  logic [ACC_W-1:0]          score_q;
  logic                      class_vld_q;
  logic                      busy_q;
  logic                      frame_err_q;
  logic                      drop_err_q;
  logic signed [ACC_W-1:0]   cur;
  logic                      take;
  logic                      last_beat;

  // Sign-extend each incoming lane to accumulator width.
  always_comb begin
    for (int unsigned c = 0; c < CHANNEL; c++) begin
      ext[c] = ACC_W'($signed(io.input_din[c*N +: N]));
    end
  end

  // Scan candidate and whether it replaces the running best.
  always_comb begin
    cur       = acc[idx];
    take      = (idx == '0) || (cur > best);
    last_beat = (cnt == LAST_CNT);
  end

  // Control FSM with accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      cnt         <= '0;
      idx         <= '0;
      best        <= '0;
      best_idx    <= '0;
      class_q     <= '0;
      score_q     <= '0;
      class_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      drop_err_q  <= 1'b0;
      for (int unsigned c = 0; c < CHANNEL; c++) acc[c] <= '0;
    end else begin
      class_vld_q <= 1'b0;
      frame_err_q <= 1'b0;
      drop_err_q  <= 1'b0;
      case (state)
        ACCUM: begin
          if (io.input_vld) begin
            if (last_beat) begin
              for (int unsigned c = 0; c < CHANNEL; c++) acc[c] <= acc[c] + ext[c];
              cnt    <= '0;
              idx    <= '0;
              busy_q <= 1'b1;
              state  <= SCAN;
            end else if (io.input_end) begin
              frame_err_q <= 1'b1;
              cnt         <= '0;
              for (int unsigned c = 0; c < CHANNEL; c++) acc[c] <= '0;
            end else begin
              for (int unsigned c = 0; c < CHANNEL; c++) acc[c] <= acc[c] + ext[c];
              cnt <= cnt + 1'b1;
            end
          end
        end
        SCAN: begin
          drop_err_q <= io.input_vld;
          if (take) begin
            best     <= cur;
            best_idx <= idx;
          end
          // Final compare folds straight into the output registers so the
          // result is valid in the OUT cycle itself.
          if (idx == LAST_IDX) begin
            class_vld_q <= 1'b1;
            class_q     <= take ? idx : best_idx;
            score_q     <= take ? cur : best;
            state       <= OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        OUT: begin
          drop_err_q <= io.input_vld;
          busy_q     <= 1'b0;
          for (int unsigned c = 0; c < CHANNEL; c++) acc[c] <= '0;
          state      <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign io.class_dout = class_q;
  assign io.score_dout = score_q;
  assign io.class_vld  = class_vld_q;
  assign io.busy       = busy_q;
  assign io.frame_err  = frame_err_q;
  assign io.drop_err   = drop_err_q;
endmodule

// File: tb/tb_mnist_argmax.sv
// Bench for mnist_argmax: SIZE=1 and SIZE=2 instances checked against a
// per-channel sum / argmax model.
module tb_mnist_argmax;
  localparam int N = 8, CH = 10, ACC_W = 16, CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mnist_argmax_if #(.N(N), .CHANNEL(CH), .ACC_W(ACC_W), .CLASS_W(CW)) bus1 ();
  mnist_argmax_if #(.N(N), .CHANNEL(CH), .ACC_W(ACC_W), .CLASS_W(CW)) bus2 ();

  mnist_argmax #(.N(N), .CHANNEL(CH), .SIZE(1), .ACC_W(ACC_W), .CLASS_W(CW))
    dut1 (.clk(clk), .rst_n(rst_n), .io(bus1));
  mnist_argmax #(.N(N), .CHANNEL(CH), .SIZE(2), .ACC_W(ACC_W), .CLASS_W(CW))
    dut2 (.clk(clk), .rst_n(rst_n), .io(bus2));

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CH*N-1:0] pack(input int l[CH]);
    logic [CH*N-1:0] p;
    for (int c = 0; c < CH; c++) p[c*N +: N] = 8'(l[c]);
    return p;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [CH*N-1:0] d, input logic e);
    if (sel == 1) begin
      bus1.input_vld = v; bus1.input_din = d; bus1.input_end = e;
    end else begin
      bus2.input_vld = v; bus2.input_din = d; bus2.input_end = e;
    end
  endtask

  // Present one beat for one cycle; returns in the cycle after it was sampled.
  task automatic send_beat(input int sel, input int l[CH], input logic e);
    drive(sel, 1'b1, pack(l), e);
    tick();
    drive(sel, 1'b0, '0, 1'b0);
  endtask

  function automatic logic o_vld(input int sel);
    return (sel == 1) ? bus1.class_vld : bus2.class_vld;
  endfunction

  // Wait (bounded) for class_vld; lat = cycle number relative to last beat.
  task automatic wait_vld(input int sel, input int start, output int lat,
                          output int cls, output int sc);
    lat = -1; cls = -1; sc = -1;
    for (int t = start; t < start + 30; t++) begin
      if (o_vld(sel)) begin
        lat = t;
        cls = (sel == 1) ? int'(bus1.class_dout) : int'(bus2.class_dout);
        sc  = (sel == 1) ? int'(bus1.score_dout) : int'(bus2.score_dout);
        break;
      end
      tick();
    end
  endtask

  // Reference: per-channel sums already formed; argmax, first max wins.
  task automatic model(input int s[CH], output int cls, output int sc);
    cls = 0;
    for (int c = 1; c < CH; c++) if (s[c] > s[cls]) cls = c;
    sc = s[cls] & 16'hFFFF;
  endtask

  task automatic check_result(input string name, input int lat, input int cls, input int sc,
                              input int elat, input int ecls, input int esc);
    checks++;
    if (lat !== elat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
    end
    checks++;
    if (cls !== ecls) begin
      errors++; $display("FAIL %s class: got %0d want %0d", name, cls, ecls);
    end
    checks++;
    if (sc !== esc) begin
      errors++; $display("FAIL %s score: got 0x%0h want 0x%0h", name, sc, esc);
    end
  endtask

  task automatic test_reset();
    drive(1, 1'b0, '0, 1'b0);
    drive(2, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({bus1.class_vld, bus1.busy, bus1.frame_err, bus1.drop_err, bus1.class_dout, bus1.score_dout} !== '0) begin
      errors++; $display("FAIL reset_dut1: outputs nonzero class=%0d score=%0h", bus1.class_dout, bus1.score_dout);
    end
    checks++;
    if ({bus2.class_vld, bus2.busy, bus2.frame_err, bus2.drop_err, bus2.class_dout, bus2.score_dout} !== '0) begin
      errors++; $display("FAIL reset_dut2: outputs nonzero class=%0d score=%0h", bus2.class_dout, bus2.score_dout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int l[CH] = '{default: 0};
    l[0] = -3; l[1] = 5; l[2] = 2;
    send_beat(1, l, 1'b1);
    for (int t = 1; t <= 13; t++) begin
      checks++;
      if (bus1.busy !== (t <= 11)) begin
        errors++; $display("FAIL basic_busy cycle %0d: got %b want %b", t, bus1.busy, (t <= 11));
      end
      checks++;
      if (bus1.class_vld !== (t == 11)) begin
        errors++; $display("FAIL basic_vld cycle %0d: got %b want %b", t, bus1.class_vld, (t == 11));
      end
      if (t == 11) begin
        checks++;
        if (bus1.class_dout !== 4'd1 || bus1.score_dout !== 16'd5) begin
          errors++; $display("FAIL basic_result: got %0d/%0d want 1/5", bus1.class_dout, bus1.score_dout);
        end
      end
      if (t == 13) begin
        checks++;
        if (bus1.class_dout !== 4'd1 || bus1.score_dout !== 16'd5) begin
          errors++; $display("FAIL basic_hold: got %0d/%0d want 1/5", bus1.class_dout, bus1.score_dout);
        end
      end
      tick();
    end
  endtask

  task automatic test_tie_and_signed();
    int l[CH] = '{default: 0};
    int lat, cls, sc;
    l[3] = 100; l[7] = 100;
    send_beat(1, l, 1'b1);
    wait_vld(1, 1, lat, cls, sc);
    check_result("tie", lat, cls, sc, 11, 3, 100);
    tick();
    l = '{default: -128};
    l[9] = -1;
    send_beat(1, l, 1'b0);
    wait_vld(1, 1, lat, cls, sc);
    check_result("signed", lat, cls, sc, 11, 9, 16'hFFFF);
    tick();
  endtask

  task automatic test_random_size1();
    int l[CH];
    int lat, cls, sc, ecls, esc;
    for (int f = 0; f < 25; f++) begin
      for (int c = 0; c < CH; c++) l[c] = int'($signed(8'($urandom)));
      if (f % 3 == 0) l[$urandom_range(5, 9)] = l[$urandom_range(0, 4)];
      model(l, ecls, esc);
      send_beat(1, l, 1'(f % 2));
      wait_vld(1, 1, lat, cls, sc);
      check_result("rand1", lat, cls, sc, 11, ecls, esc);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int l[CH];
    int lat, cls, sc, ecls, esc;
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < CH; c++) l[c] = int'($signed(8'($urandom)));
      model(l, ecls, esc);
      send_beat(1, l, 1'b1);
      wait_vld(1, 1, lat, cls, sc);
      check_result("b2b", lat, cls, sc, 11, ecls, esc);
      tick(); // minimum spacing: next last beat in cycle CHANNEL+2
    end
  endtask

  task automatic test_size2_gaps();
    int l[CH] = '{default: 0};
    int lat, cls, sc;
    int ch2[4] = '{100, 100, 100, 127};
    for (int b = 0; b < 4; b++) begin
      l[0] = 127; l[2] = ch2[b];
      send_beat(2, l, 1'(b == 3));
      if (b < 3) begin tick(); tick(); end
    end
    wait_vld(2, 1, lat, cls, sc);
    check_result("size2", lat, cls, sc, 11, 0, 508);
    tick();
  endtask

  task automatic test_random_size2();
    int l[CH];
    int s[CH];
    int lat, cls, sc, ecls, esc;
    for (int f = 0; f < 10; f++) begin
      s = '{default: 0};
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < CH; c++) begin
          l[c] = int'($signed(8'($urandom)));
          s[c] += l[c];
        end
        send_beat(2, l, 1'b0);
        if (b < 3) repeat ($urandom_range(0, 2)) tick();
      end
      model(s, ecls, esc);
      wait_vld(2, 1, lat, cls, sc);
      check_result("rand2", lat, cls, sc, 11, ecls, esc);
      tick();
    end
  endtask

  task automatic test_frame_err();
    int l[CH] = '{default: 0};
    int lat, cls, sc;
    l[0] = 50;
    send_beat(2, l, 1'b0);
    send_beat(2, l, 1'b1);
    checks++;
    if (bus2.frame_err !== 1'b1) begin
      errors++; $display("FAIL frame_err_pulse: got %b want 1", bus2.frame_err);
    end
    tick();
    checks++;
    if (bus2.frame_err !== 1'b0 || bus2.busy !== 1'b0) begin
      errors++; $display("FAIL frame_err_clear: got err=%b busy=%b want 0/0", bus2.frame_err, bus2.busy);
    end
    for (int t = 0; t < 14; t++) begin
      checks++;
      if (bus2.class_vld !== 1'b0) begin
        errors++; $display("FAIL frame_err_novld cycle %0d: got 1 want 0", t);
      end
      tick();
    end
    l = '{default: 0};
    l[5] = 1;
    for (int b = 0; b < 4; b++) send_beat(2, l, 1'(b == 3));
    wait_vld(2, 1, lat, cls, sc);
    check_result("after_abort", lat, cls, sc, 11, 5, 4);
    tick();
  endtask

  task automatic test_drop();
    int l[CH] = '{default: 0};
    int inj[CH] = '{default: 0};
    int lat, cls, sc;
    l[2] = 60;
    inj[4] = 127;
    send_beat(1, l, 1'b1);
    tick(); tick();            // now in SCAN cycle 3
    send_beat(1, inj, 1'b0);   // now cycle 4
    checks++;
    if (bus1.drop_err !== 1'b1) begin
      errors++; $display("FAIL drop_pulse: got %b want 1", bus1.drop_err);
    end
    tick();
    checks++;
    if (bus1.drop_err !== 1'b0) begin
      errors++; $display("FAIL drop_clear: got %b want 0", bus1.drop_err);
    end
    wait_vld(1, 5, lat, cls, sc);
    check_result("drop", lat, cls, sc, 11, 2, 60);
    tick();
    l = '{default: 0};
    l[1] = 10;
    send_beat(1, l, 1'b1);
    wait_vld(1, 1, lat, cls, sc);
    check_result("post_drop", lat, cls, sc, 11, 1, 10);
    tick();
  endtask

  task automatic test_reset_mid_scan();
    int l[CH] = '{default: 0};
    int p[CH] = '{default: 0};
    int lat, cls, sc;
    l[6] = 90;
    p[3] = 100;
    send_beat(1, l, 1'b1);
    send_beat(2, p, 1'b0);     // leave dut2 mid-frame too
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus1.class_vld, bus1.busy, bus1.class_dout, bus1.score_dout} !== '0) begin
      errors++; $display("FAIL midreset_outputs: class=%0d score=%0h busy=%b want 0", bus1.class_dout, bus1.score_dout, bus1.busy);
    end
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 14; t++) begin
      checks++;
      if (bus1.class_vld !== 1'b0 || bus1.score_dout !== 16'd0) begin
        errors++; $display("FAIL midreset_novld cycle %0d: vld=%b score=%0h want 0/0", t, bus1.class_vld, bus1.score_dout);
      end
      tick();
    end
    l = '{default: 0};
    l[8] = 7;
    send_beat(1, l, 1'b1);
    wait_vld(1, 1, lat, cls, sc);
    check_result("midreset_next1", lat, cls, sc, 11, 8, 7);
    tick();
    p = '{default: 0};
    p[1] = 2;
    for (int b = 0; b < 4; b++) send_beat(2, p, 1'b0);
    wait_vld(2, 1, lat, cls, sc);
    check_result("midreset_next2", lat, cls, sc, 11, 1, 8);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_and_signed();
    test_random_size1();
    test_back_to_back();
    test_size2_gaps();
    test_random_size2();
    test_frame_err();
    test_drop();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
